// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_t;

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK_WAIT
    } rx_state_t;

    // One FIFO entry: error status alongside the LSB-aligned character.
    typedef struct packed {
        logic       frame_err;
        logic       parity_err;
        logic [7:0] data;
    } rx_word_t;

    // Clock cycles per bit, rounded to nearest.
    function automatic int unsigned bit_cycles(input int unsigned clock_hz, input int unsigned baud);
        return (clock_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Synchronous FIFO with a registered head word; accepts a write when full
// provided the head is popped in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     valid_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             valid_q, full_q;
    logic             pop_c, push_c;

    always_comb begin
        pop_c   = pop_i & valid_q;
        push_c  = push_i & (~full_q | pop_c);
        wr_d    = wr_q + PTR_W'(push_c);
        rd_d    = rd_q + PTR_W'(pop_c);
        level_d = level_q;
        if (push_c && !pop_c) begin
            level_d = level_q + 1'b1;
        end else if (pop_c && !push_c) begin
            level_d = level_q - 1'b1;
        end
        // Bypass the incoming word when it lands in the slot becoming head.
        head_d = (push_c && (wr_q == rd_d)) ? data_i : mem_q[rd_d];
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_q] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            head_q  <= '0;
            valid_q <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            head_q  <= head_d;
            valid_q <= (level_d != '0);
            full_q  <= (level_d == LVL_W'(DEPTH));
        end
    end

    assign data_o  = head_q;
    assign valid_o = valid_q;
    assign full_o  = full_q;
    assign level_o = level_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with mid-bit 2-of-3 majority sampling, parity/framing/break
// detection and a valid/ready drained receive FIFO.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_HZ   = 20_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          uart_rx_pin,
    output logic [7:0]                    m_data,
    output logic                          m_frame_err,
    output logic                          m_parity_err,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          overrun,
    input  logic                          clear_overrun,
    output logic                          break_det,
    output logic                          rx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned BIT_CYCLES  = bit_cycles(CLOCK_HZ, BAUD);
    localparam int unsigned HALF_CYCLES = BIT_CYCLES / 2;
    localparam int unsigned CNT_W       = $clog2(BIT_CYCLES);
    localparam int unsigned IDX_W       = 3;
    localparam int unsigned WORD_W      = $bits(rx_word_t);
    localparam parity_t     PAR_MODE    = parity_t'(2'(PARITY));

    logic                 rx_meta_q, rx_s_q, rx_prev_q;
    rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [1:0]           samp_q, samp_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 par_bit_q, par_bit_d;
    logic                 ferr_q, ferr_d;
    logic                 stop_one_q, stop_one_d;
    logic                 break_det_q, rx_busy_q, overrun_q;
    logic                 edge_c, mid_c, end_c, bit_c, last_stop_c;
    logic                 push_c, brk_c, fe_c, perr_c, drop_c;
    logic                 fifo_full;
    rx_word_t             word_c, head;

    // Synchroniser resets low so the line must be seen genuinely idle first.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b0;
            rx_s_q    <= 1'b0;
            rx_prev_q <= 1'b0;
        end else begin
            rx_meta_q <= uart_rx_pin;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    always_comb begin
        edge_c      = rx_prev_q & ~rx_s_q;
        mid_c       = (cnt_q == CNT_W'(HALF_CYCLES + 1));
        end_c       = (cnt_q == CNT_W'(BIT_CYCLES - 1));
        bit_c       = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
        last_stop_c = (stop_idx_q == 1'(STOP_BITS - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= WAIT_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_IDLE: if (rx_s_q) state_d = IDLE;
            IDLE:      if (edge_c) state_d = START;
            START: begin
                if (mid_c && bit_c) begin
                    state_d = IDLE;
                end else if (end_c) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (end_c && (bit_idx_q == IDX_W'(DATA_BITS - 1))) begin
                    state_d = (PAR_MODE != PAR_NONE) ? uart_pkg::PARITY : STOP;
                end
            end
            uart_pkg::PARITY: if (end_c) state_d = STOP;
            // Leave at the last stop-bit midpoint to catch a close next start.
            STOP: begin
                if (mid_c && last_stop_c) begin
                    state_d = brk_c ? BREAK_WAIT : IDLE;
                end
            end
            BREAK_WAIT: if (rx_s_q) state_d = IDLE;
            default:    state_d = WAIT_IDLE;
        endcase
    end

    always_comb begin
        push_c = (state_q == STOP) && mid_c && last_stop_c;
        brk_c  = push_c && (shift_q == '0) && !par_bit_q && !stop_one_q && !bit_c;
        fe_c   = ferr_q | ~bit_c;
        case (PAR_MODE)
            PAR_ODD:  perr_c = ~((^shift_q) ^ par_bit_q);
            PAR_EVEN: perr_c = (^shift_q) ^ par_bit_q;
            default:  perr_c = 1'b0;
        endcase
        word_c.frame_err  = fe_c;
        word_c.parity_err = perr_c;
        word_c.data       = 8'(shift_q);
    end

    // Bit timing, majority samples and frame accumulation.
    always_comb begin
        cnt_d      = cnt_q;
        samp_d     = samp_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        par_bit_d  = par_bit_q;
        ferr_d     = ferr_q;
        stop_one_d = stop_one_q;
        if (state_q == IDLE) begin
            cnt_d      = edge_c ? CNT_W'(1) : '0;
            shift_d    = '0;
            bit_idx_d  = '0;
            stop_idx_d = 1'b0;
            par_bit_d  = 1'b0;
            ferr_d     = 1'b0;
            stop_one_d = 1'b0;
        end else if (state_q inside {START, DATA, uart_pkg::PARITY, STOP}) begin
            cnt_d = end_c ? '0 : cnt_q + 1'b1;
            if (cnt_q == CNT_W'(HALF_CYCLES - 1)) samp_d[0] = rx_s_q;
            if (cnt_q == CNT_W'(HALF_CYCLES))     samp_d[1] = rx_s_q;
            if (mid_c) begin
                if (state_q == DATA)             shift_d   = {bit_c, shift_q[DATA_BITS-1:1]};
                if (state_q == uart_pkg::PARITY) par_bit_d = bit_c;
                if (state_q == STOP) begin
                    ferr_d     = ferr_q | ~bit_c;
                    stop_one_d = stop_one_q | bit_c;
                end
            end
            if (end_c && (state_q == DATA)) bit_idx_d  = bit_idx_q + 1'b1;
            if (end_c && (state_q == STOP)) stop_idx_d = ~stop_idx_q;
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            samp_q     <= '0;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            par_bit_q  <= 1'b0;
            ferr_q     <= 1'b0;
            stop_one_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            samp_q     <= samp_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            par_bit_q  <= par_bit_d;
            ferr_q     <= ferr_d;
            stop_one_q <= stop_one_d;
        end
    end

    assign drop_c = push_c && fifo_full && !(m_valid && m_ready);

    // Overrun set wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            break_det_q <= 1'b0;
            rx_busy_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            break_det_q <= brk_c;
            rx_busy_q   <= !(state_d inside {IDLE, WAIT_IDLE});
            if (drop_c) begin
                overrun_q <= 1'b1;
            end else if (clear_overrun) begin
                overrun_q <= 1'b0;
            end
        end
    end

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_c),
        .data_i  (word_c),
        .pop_i   (m_ready),
        .data_o  (head),
        .valid_o (m_valid),
        .full_o  (fifo_full),
        .level_o (fifo_level)
    );

    assign m_data       = head.data;
    assign m_frame_err  = head.frame_err;
    assign m_parity_err = head.parity_err;
    assign break_det    = break_det_q;
    assign rx_busy      = rx_busy_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench: an 8N1 receiver (a) and a 7E1 receiver (b) driven with
// directed frames; monitors pop expected entries on each FIFO handshake.
module tb_uart_rx_fifo;

    localparam int BIT  = 174;
    localparam int HALF = 87;

    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       pe;
        bit         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_a, rx_b, ready_a, ready_b, clr_a, clr_b;
    logic [7:0] data_a, data_b;
    logic       fe_a, fe_b, pe_a, pe_b, valid_a, valid_b;
    logic       ovr_a, ovr_b, brk_a, brk_b, busy_a, busy_b;
    logic [3:0] lvl_a, lvl_b;

    exp_t exp_a[$];
    exp_t exp_b[$];
    int   lat_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   brk_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_fifo dut_a (
        .clk(clk), .reset(reset), .uart_rx_pin(rx_a),
        .m_data(data_a), .m_frame_err(fe_a), .m_parity_err(pe_a),
        .m_valid(valid_a), .m_ready(ready_a),
        .overrun(ovr_a), .clear_overrun(clr_a), .break_det(brk_a),
        .rx_busy(busy_a), .fifo_level(lvl_a)
    );

    uart_rx_fifo #(.DATA_BITS(7), .PARITY(2)) dut_b (
        .clk(clk), .reset(reset), .uart_rx_pin(rx_b),
        .m_data(data_b), .m_frame_err(fe_b), .m_parity_err(pe_b),
        .m_valid(valid_b), .m_ready(ready_b),
        .overrun(ovr_b), .clear_overrun(clr_b), .break_det(brk_b),
        .rx_busy(busy_b), .fifo_level(lvl_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic exp_push(input int ln, input logic [7:0] d, input logic fe, input logic pe, input bit lat);
        exp_t e;
        e.d = d; e.fe = fe; e.pe = pe; e.lat = lat;
        if (ln == 0) exp_a.push_back(e);
        else         exp_b.push_back(e);
    endtask

    task automatic drive(input int ln, input logic v, input int n);
        if (ln == 0) rx_a = v;
        else         rx_b = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input int ln, input logic [7:0] d, input int nbits, input int pbit,
                        input logic stopv, input bit lat);
        drive(ln, 1'b0, BIT);
        for (int i = 0; i < nbits; i++) drive(ln, d[i], BIT);
        if (pbit >= 0) drive(ln, 1'(pbit), BIT);
        drive(ln, stopv, HALF);
        if (lat) lat_q.push_back(cyc);
        drive(ln, stopv, BIT - HALF);
        if (ln == 0) rx_a = 1'b1;
        else         rx_b = 1'b1;
    endtask

    task automatic drain(input int ln, input int budget);
        int n = 0;
        while (((ln == 0) ? exp_a.size() : exp_b.size()) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk((ln == 0) ? "a_drain_pending" : "b_drain_pending",
            32'((ln == 0) ? exp_a.size() : exp_b.size()), 0);
    endtask

    initial begin : mon_a
        exp_t e;
        int   l;
        forever begin
            @(negedge clk);
            #1;
            if (valid_a && ready_a) begin
                if (exp_a.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL a_unexpected_pop: got data %02h fe %0b pe %0b, expected no entry",
                             data_a, fe_a, pe_a);
                end else begin
                    e = exp_a.pop_front();
                    chk("a_data", 32'(data_a), 32'(e.d));
                    chk("a_frame_err", 32'(fe_a), 32'(e.fe));
                    chk("a_parity_err", 32'(pe_a), 32'(e.pe));
                    if (e.lat) begin
                        l = (lat_q.size() != 0) ? cyc - lat_q.pop_front() : -1;
                        chk("a_latency_within_half_plus_4", 32'(l >= 0 && l <= HALF + 4), 1);
                    end
                end
            end
        end
    end

    initial begin : mon_b
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (valid_b && ready_b) begin
                if (exp_b.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL b_unexpected_pop: got data %02h fe %0b pe %0b, expected no entry",
                             data_b, fe_b, pe_b);
                end else begin
                    e = exp_b.pop_front();
                    chk("b_data", 32'(data_b), 32'(e.d));
                    chk("b_frame_err", 32'(fe_b), 32'(e.fe));
                    chk("b_parity_err", 32'(pe_b), 32'(e.pe));
                end
            end
        end
    end

    initial begin : brk_mon
        forever begin
            @(negedge clk);
            #1;
            if (brk_a) brk_cnt++;
        end
    end

    initial begin : watchdog
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: bench still running after 95000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        rx_a = 1'b1; rx_b = 1'b1;
        ready_a = 1'b1; ready_b = 1'b1;
        clr_a = 1'b0; clr_b = 1'b0;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_m_valid", 32'(valid_a), 0);
        chk("rst_m_data", 32'(data_a), 0);
        chk("rst_frame_err", 32'(fe_a), 0);
        chk("rst_parity_err", 32'(pe_a), 0);
        chk("rst_overrun", 32'(ovr_a), 0);
        chk("rst_break_det", 32'(brk_a), 0);
        chk("rst_rx_busy", 32'(busy_a), 0);
        chk("rst_fifo_level", 32'(lvl_a), 0);
        chk("rst_b_level", 32'(lvl_b), 0);
        chk("rst_b_status", 32'({valid_b, ovr_b, brk_b, busy_b}), 0);
        repeat (10) @(negedge clk);

        // Back-to-back characters with head latency check
        exp_push(0, 8'h48, 1'b0, 1'b0, 1'b1);
        exp_push(0, 8'h69, 1'b0, 1'b0, 1'b1);
        exp_push(0, 8'h0A, 1'b0, 1'b0, 1'b1);
        send(0, 8'h48, 8, -1, 1'b1, 1'b1);
        send(0, 8'h69, 8, -1, 1'b1, 1'b1);
        send(0, 8'h0A, 8, -1, 1'b1, 1'b1);
        drain(0, 300);

        // 7E1: good parity, then bad parity
        exp_push(1, 8'h41, 1'b0, 1'b0, 1'b0);
        send(1, 8'h41, 7, 0, 1'b1, 1'b0);
        exp_push(1, 8'h41, 1'b0, 1'b1, 1'b0);
        send(1, 8'h41, 7, 1, 1'b1, 1'b0);
        drain(1, 300);

        // False start
        drive(0, 1'b0, 20);
        chk("false_start_busy_mid", 32'(busy_a), 1);
        drive(0, 1'b0, 20);
        drive(0, 1'b1, 150);
        chk("false_start_busy_end", 32'(busy_a), 0);
        chk("false_start_level", 32'(lvl_a), 0);

        // Overrun: ten characters into an eight-deep stalled FIFO
        ready_a = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) exp_push(0, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
            send(0, 8'(8'h30 + i), 8, -1, 1'b1, 1'b0);
        end
        repeat (10) @(negedge clk);
        chk("ovr_level_full", 32'(lvl_a), 8);
        chk("ovr_flag_set", 32'(ovr_a), 1);
        chk("ovr_head_stable", 32'(data_a), 32'h30);
        chk("ovr_valid_held", 32'(valid_a), 1);
        ready_a = 1'b1;
        drain(0, 100);
        @(negedge clk);
        chk("ovr_sticky_after_drain", 32'(ovr_a), 1);
        chk("ovr_level_empty", 32'(lvl_a), 0);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        @(negedge clk);
        chk("ovr_cleared", 32'(ovr_a), 0);

        // Break: line held low for three frame times
        exp_push(0, 8'h00, 1'b1, 1'b0, 1'b0);
        drive(0, 1'b0, 3 * 10 * BIT);
        drive(0, 1'b1, 50);
        drain(0, 200);
        chk("break_pulses", 32'(brk_cnt), 1);
        chk("break_busy_idle", 32'(busy_a), 0);
        exp_push(0, 8'h55, 1'b0, 1'b0, 1'b0);
        send(0, 8'h55, 8, -1, 1'b1, 1'b0);
        drain(0, 200);
        chk("break_pulses_after_recover", 32'(brk_cnt), 1);

        // Reset mid-frame flushes FIFO and waits for idle line
        ready_a = 1'b0;
        exp_push(0, 8'h11, 1'b0, 1'b0, 1'b0);
        send(0, 8'h11, 8, -1, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        chk("prereset_level", 32'(lvl_a), 1);
        drive(0, 1'b0, 3 * BIT);
        chk("prereset_busy", 32'(busy_a), 1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_a.delete();
        @(negedge clk);
        chk("postreset_valid", 32'(valid_a), 0);
        chk("postreset_level", 32'(lvl_a), 0);
        chk("postreset_busy", 32'(busy_a), 0);
        drive(0, 1'b0, 1000);
        chk("low_line_level", 32'(lvl_a), 0);
        chk("low_line_busy", 32'(busy_a), 0);
        chk("low_line_valid", 32'(valid_a), 0);
        drive(0, 1'b1, 20);
        ready_a = 1'b1;
        exp_push(0, 8'h3C, 1'b0, 1'b0, 1'b0);
        send(0, 8'h3C, 8, -1, 1'b1, 1'b0);
        drain(0, 200);
        repeat (20) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
